instr_asm_loader: RTL and testbench

INSTR_ASM_LOADER -- requirements
Module: instr_asm_loader

---
 rtl/cpu_ctrl_pkg.sv | 26 ++
 rtl/instr_encoder.sv | 45 ++++
 rtl/instr_asm_loader.sv | 111 +++++++++++
 tb/tb_instr_asm_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, request kinds and instruction field positions
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_ADDI  = 3'd1;
    localparam logic [2:0] KIND_SLTI  = 3'd2;
    localparam logic [2:0] KIND_BEQ   = 3'd3;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } loader_state_e;

endpackage

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - combinational packing of request fields into an instruction word
module instr_encoder
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[RS_LSB +: 5] = rs;
        word[RT_LSB +: 5] = rt;
        case (kind)
            KIND_RTYPE: begin
                word[OP_LSB +: 6]    = OP_RTYPE;
                word[RD_LSB +: 5]    = rd;
                word[FUNCT_LSB +: 6] = funct;
            end
            KIND_ADDI: begin
                word[OP_LSB +: 6]   = OP_ADDI;
                word[IMM_LSB +: 16] = imm;
            end
            KIND_SLTI: begin
                word[OP_LSB +: 6]   = OP_SLTI;
                word[IMM_LSB +: 16] = imm;
            end
            KIND_BEQ: begin
                word[OP_LSB +: 6]   = OP_BEQ;
                word[IMM_LSB +: 16] = imm;
            end
            default: begin
                word    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_asm_loader.sv
// rtl/instr_asm_loader.sv - encodes instruction requests and writes them sequentially into imem
// Optional running XOR checksum of acknowledged words: ASM_LOADER_CHECKSUM_EN
module instr_asm_loader
    import cpu_ctrl_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [2:0]               req_kind_i,
    input  logic [4:0]               rs_i,
    input  logic [4:0]               rt_i,
    input  logic [4:0]               rd_i,
    input  logic [5:0]               funct_i,
    input  logic [15:0]              imm_i,
    input  logic                     clear_i,
    output logic                     imem_we_o,
    output logic [31:0]              imem_addr_o,
    output logic [31:0]              imem_data_o,
    input  logic                     imem_ack_i,
    output logic [$clog2(DEPTH):0]   count_o,
`ifdef ASM_LOADER_CHECKSUM_EN
    output logic [31:0]              csum_o,
`endif
    output logic                     full_o,
    output logic                     err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    loader_state_e state_q, state_d;
    logic [31:0]   addr_q, data_q, enc_word;
    logic [CW-1:0] count_q;
    logic          err_q, up_q, enc_illegal;
    logic          accept, ack_fire, idle_clear;

    instr_encoder u_encoder (
        .kind    (req_kind_i),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .funct   (funct_i),
        .imm     (imm_i),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // up_q keeps ready low until the first edge after reset release
    assign full_o      = (count_q == DEPTH_C);
    assign req_ready_o = up_q && (state_q == ST_IDLE) && !full_o && !clear_i;
    assign accept      = req_valid_i && req_ready_o;
    assign ack_fire    = (state_q == ST_WRITE) && imem_ack_i;
    assign idle_clear  = (state_q == ST_IDLE) && clear_i;

    assign imem_we_o   = (state_q == ST_WRITE);
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign count_o     = count_q;
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && !enc_illegal) state_d = ST_WRITE;
            ST_WRITE: if (imem_ack_i)             state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            up_q  <= 1'b1;
            err_q <= accept && enc_illegal;
            if (accept && !enc_illegal) data_q <= enc_word;
            if (ack_fire) begin
                addr_q  <= addr_q + 32'd4;
                count_q <= count_q + 1'b1;
            end else if (idle_clear) begin
                addr_q  <= BASE_ADDR;
                count_q <= '0;
            end
        end
    end

`ifdef ASM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
    assign csum_o = csum_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)          csum_q <= '0;
        else if (ack_fire)   csum_q <= csum_q ^ data_q;
        else if (idle_clear) csum_q <= '0;
    end
`endif

endmodule

// File: tb/tb_instr_asm_loader.sv
// tb/tb_instr_asm_loader.sv - directed self-checking bench for instr_asm_loader (DEPTH=2)
module tb_instr_asm_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic        clear = 1'b0;
    logic        we;
    logic [31:0] addr, data;
    logic        ack = 1'b0;
    logic [1:0]  count;
    logic        full, err;
`ifdef ASM_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_asm_loader #(.DEPTH(2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (valid),
        .req_ready_o (ready),
        .req_kind_i  (kind),
        .rs_i        (rs),
        .rt_i        (rt),
        .rd_i        (rd),
        .funct_i     (funct),
        .imm_i       (imm),
        .clear_i     (clear),
        .imem_we_o   (we),
        .imem_addr_o (addr),
        .imem_data_o (data),
        .imem_ack_i  (ack),
        .count_o     (count),
`ifdef ASM_LOADER_CHECKSUM_EN
        .csum_o      (csum),
`endif
        .full_o      (full),
        .err_o       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; ack = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // returns #1 after the accepting edge
    task automatic issue(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] f, input logic [15:0] im);
        int n = 0;
        @(negedge clk);
        kind = k; rs = s; rt = t; rd = d; funct = f; imm = im; valid = 1'b1;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic give_ack(input int delay);
        repeat (delay) @(negedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    initial begin
        // reset state while held
        #2;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_we",    32'(we),    32'd0);
        check("rst_addr",  addr,       32'h0);
        check("rst_data",  data,       32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full",  32'(full),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 32'(ready), 32'd1);
`ifdef ASM_LOADER_CHECKSUM_EN
        check("csum_reset", csum, 32'h0);
`endif

        // R-type, ack one cycle after we
        issue(3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0);
        check("r_we",   32'(we),    32'd1);
        check("r_addr", addr,       32'h0);
        check("r_data", data,       32'h0022_1820);
        check("r_ready_busy", 32'(ready), 32'd0);
        give_ack(0);
        check("r_count", 32'(count), 32'd1);
        check("r_addr_next", addr,   32'h4);
        check("r_we_done", 32'(we),  32'd0);
        check("r_ready_again", 32'(ready), 32'd1);

        // ack while idle must be ignored
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
        check("idle_ack_count", 32'(count), 32'd1);
        check("idle_ack_addr",  addr,       32'h4);

        // addi then beq, filling DEPTH=2
        do_reset();
        issue(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'hFFFF);
        check("addi_data", data, 32'h2008_FFFF);
        check("addi_addr", addr, 32'h0);
        give_ack(1);
`ifdef ASM_LOADER_CHECKSUM_EN
        check("csum_one", csum, 32'h2008_FFFF);
`endif
        issue(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0003);
        check("beq_data", data, 32'h1109_0003);
        check("beq_addr", addr, 32'h4);
        check("beq_full_before_ack", 32'(full), 32'd0);
        give_ack(0);
        check("full_set",   32'(full),  32'd1);
        check("full_count", 32'(count), 32'd2);
        check("full_addr",  addr,       32'h8);

        // third request stalls while full
        @(negedge clk);
        kind = 3'd2; valid = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_ready", 32'(ready), 32'd0);
        check("stall_we",    32'(we),    32'd0);
        check("stall_count", 32'(count), 32'd2);
        valid = 1'b0;
        clear = 1'b1;
        #1;
        check("clear_ready_low", 32'(ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        check("clear_addr",  addr,       32'h0);
        check("clear_count", 32'(count), 32'd0);
        check("clear_full",  32'(full),  32'd0);
        check("clear_ready", 32'(ready), 32'd1);
`ifdef ASM_LOADER_CHECKSUM_EN
        check("csum_clear", csum, 32'h0);
`endif

        // illegal kind
        issue(3'd5, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1);
        check("ill_err",   32'(err),   32'd1);
        check("ill_we",    32'(we),    32'd0);
        @(posedge clk); #1;
        check("ill_err_drop", 32'(err),   32'd0);
        check("ill_count",    32'(count), 32'd0);
        check("ill_addr",     addr,       32'h0);

`ifdef ASM_LOADER_CHECKSUM_EN
        do_reset();
        issue(3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0);
        give_ack(0);
        issue(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'hFFFF);
        give_ack(0);
        check("csum_two", csum, 32'h202A_E7DF);
`endif

        // withheld ack, then reset mid-write
        do_reset();
        issue(3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0);
        give_ack(0);
        issue(3'd2, 5'd4, 5'd5, 5'd0, 6'd0, 16'h8000);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("hold_we",   32'(we), 32'd1);
            check("hold_addr", addr,    32'h4);
            check("hold_data", data,    32'h2885_8000);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_we",    32'(we),    32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_addr",  addr,       32'h0);
        check("midrst_data",  data,       32'h0);
        check("midrst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_we",    32'(we),    32'd0);
        check("post_rst_ready", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
